// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed display scanner.
// Digit codes are 4-bit BCD nibbles; enables are one-hot, digit 0 rightmost.
package display_pkg;

    localparam int MAX_DIGITS = 8;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] sel);
        return MAX_DIGITS'(1) << sel;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Digit-slot timer: cnt runs 0..DIV-1 inside a slot, idx selects the digit.
// frame_end marks the last cycle of the last slot, i.e. the frame boundary edge.
module slot_timer #(
    parameter int DIV    = 50000,
    parameter int DIGITS = 4,
    parameter int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1,
    parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic slot_end;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed BCD display driver with per-slot blanking, leading-zero
// suppression and a frame-synchronous valid/ready load path.
module display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  lz_blank,
    output logic [3:0]            number,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                frame_end;

    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] pending_val;
    logic                pending;
    logic                live;
    logic                xfer;

    bcd_digit_t          digit [DIGITS];
    logic [DIGITS-1:0]   upper_zero;
    logic                lit;
    logic                suppress;
    bcd_digit_t          num_p0;
    logic [DIGITS-1:0]   en_p0;

    slot_timer #(
        .DIV    (DIV),
        .DIGITS (DIGITS),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .idx       (idx),
        .frame_end (frame_end)
    );

    // live keeps value_ready low until the first cycle after reset is released
    assign value_ready = live && !pending;
    assign xfer        = value_valid && value_ready;

    // Load path: one value may wait in pending_val; it reaches shadow only at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            live        <= 1'b0;
            pending     <= 1'b0;
            pending_val <= '0;
            shadow      <= '0;
        end else begin
            live <= 1'b1;
            if (frame_end && pending) begin
                shadow  <= pending_val;
                pending <= 1'b0;
            end else if (xfer) begin
                pending_val <= value_in;
                pending     <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            digit[k] = shadow[4*k +: 4];
        end
    end

    // upper_zero[k]: nibbles k..DIGITS-1 are all zero
    always_comb begin
        logic z;
        upper_zero = '0;
        for (int k = 0; k < DIGITS; k++) begin
            z = 1'b1;
            for (int m = k; m < DIGITS; m++) begin
                if (digit[m] != 4'd0) begin
                    z = 1'b0;
                end
            end
            upper_zero[k] = z;
        end
    end

    // Stage p0: slot decode from the current cnt/idx
    assign lit      = (cnt >= CNT_W'(BLANK));
    assign suppress = lz_blank && (idx != '0) && upper_zero[idx];
    assign num_p0   = digit[idx];
    assign en_p0    = (lit && !suppress) ? DIGITS'(onehot(3'(idx))) : '0;

    // Stage p1: registered outputs, one cycle behind cnt/idx
    always_ff @(posedge clk) begin
        if (rst) begin
            number     <= '0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            number     <= num_p0;
            digit_en   <= en_p0;
            frame_done <= frame_end;
        end
    end

endmodule
